// File: rtl/red_pitaya_pwm_pkg.sv
// Shared constants and types for the slow-DAC PWM channels.
// The 24-bit code type is also used by the slow-DAC register block so that
// both sides agree on the base/dither split.
package red_pitaya_pwm_pkg;

    localparam int PWM_CCW      = 24;
    localparam int PWM_FULL     = 255;
    localparam int PWM_BASE_MSB = 23;
    localparam int PWM_BASE_LSB = 16;
    localparam int PWM_MASK_W   = 16;

    // One PWM code: [23:16] base high-time, [15:0] per-period dither mask
    typedef logic [PWM_CCW-1:0] pwm_code_t;

    // Threshold for one period: base plus an optional extra high count.
    // Kept 9 bits wide so base=255 with a dither bit set yields 256, not 0.
    function automatic logic [8:0] pwm_thr(input logic [7:0] base, input logic extra);
        return {1'b0, base} + {8'd0, extra};
    endfunction

endpackage

// File: rtl/red_pitaya_pwm.sv
// Sigma-delta dithered PWM for one slow analog output channel.
// An 8-bit period counter drives a registered comparator against a 9-bit
// threshold; a 4-bit period counter selects which dither bit is added to
// the base value.  The code is only resampled once per 16-period frame so
// a mid-frame update can never produce a partial or glitched frame.
module red_pitaya_pwm
    import red_pitaya_pwm_pkg::*;
#(
    parameter int          CCW  = PWM_CCW,
    parameter int unsigned FULL = PWM_FULL
) (
    input  logic           clk_i,
    input  logic           rstn_i,
    input  logic [CCW-1:0] cfg_i,
    output logic           pwm_o,
    output logic           frame_o
);

    logic [7:0]     vcnt_q, vcnt_d;
    logic [3:0]     bcnt_q, bcnt_d;
    logic [CCW-1:0] cfg_q, cfg_d;
    logic [8:0]     thr_q, thr_d;
    logic           pwm_q, pwm_d;
    logic           frame_q, frame_d;

    logic                  period_end;
    logic                  frame_end;
    logic [3:0]            bcnt_next;
    logic [PWM_MASK_W-1:0] mask_q;

    assign period_end = (vcnt_q == 8'(FULL - 1));
    assign frame_end  = period_end && (bcnt_q == 4'd15);
    assign bcnt_next  = bcnt_q + 4'd1;
    assign mask_q     = cfg_q[PWM_MASK_W-1:0];

    // Next-state logic: counters, frame-boundary sampling, per-period threshold and comparator
    always_comb begin
        vcnt_d  = vcnt_q + 8'd1;
        bcnt_d  = bcnt_q;
        cfg_d   = cfg_q;
        thr_d   = thr_q;
        frame_d = 1'b0;
        pwm_d   = ({1'b0, vcnt_q} < thr_q);

        if (period_end) begin
            vcnt_d = 8'd0;
            bcnt_d = bcnt_next;
            if (frame_end) begin
                cfg_d   = cfg_i;
                thr_d   = pwm_thr(cfg_i[PWM_BASE_MSB:PWM_BASE_LSB], cfg_i[0]);
                frame_d = 1'b1;
            end else begin
                thr_d = pwm_thr(cfg_q[PWM_BASE_MSB:PWM_BASE_LSB], mask_q[bcnt_next]);
            end
        end
    end

    // State registers; reset forces the pin low immediately, even mid-period
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vcnt_q  <= 8'd0;
            bcnt_q  <= 4'd0;
            cfg_q   <= '0;
            thr_q   <= 9'd0;
            pwm_q   <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            vcnt_q  <= vcnt_d;
            bcnt_q  <= bcnt_d;
            cfg_q   <= cfg_d;
            thr_q   <= thr_d;
            pwm_q   <= pwm_d;
            frame_q <= frame_d;
        end
    end

    assign pwm_o   = pwm_q;
    assign frame_o = frame_q;

endmodule

// File: doc/red_pitaya_pwm.md
Name: red_pitaya_pwm

Overview:
- Sigma-delta-dithered PWM generator for the slow analog outputs; the output-direction counterpart of the ADC input path.
- Runs on the PWM clock generated in the analog clocking block.
- Takes a 24-bit code per channel. Upper 8 bits set the base high-time per PWM period. Lower 16 bits add one extra high count in selected periods of a 16-period frame.
- Instantiated once per slow-DAC channel; drives an FPGA output pin.

Parameters:
- CCW, 24, configuration code width; fixed split is [23:16] base value and [15:0] dither mask.
- FULL, 255, PWM period length in clock cycles; legal range 2..255.

Ports:
- clk_i  in  1  PWM clock (pwm_clk)
- rstn_i  in  1  reset, asynchronous, active-low
- cfg_i  in  CCW  PWM code, 2's-free unsigned; sampled only at frame boundary
- pwm_o  out  1  PWM output pin drive
- frame_o  out  1  one-cycle strobe: new cfg_i sample taken on previous edge

Behaviour:
- Reset state, applied asynchronously on rstn_i low and held while low:
  - vcnt=0, bcnt=0, cfg_r=0, thr=0
  - pwm_o=0, frame_o=0
  - pwm_o goes low immediately, including mid-period.
- vcnt (8b) increments every cycle.
  - At vcnt==FULL-1 it wraps to 0 (period end).
- bcnt (4b) increments at each period end and wraps 15->0.
  - A frame is 16 periods, i.e. 16*FULL cycles (4080 at default).
- Frame end is the cycle with vcnt==FULL-1 and bcnt==15. On the next edge:
  - cfg_r <= cfg_i
  - thr <= cfg_i[23:16] + cfg_i[0]
  - frame_o <= 1 for exactly one cycle
- Other period ends: thr <= cfg_r[23:16] + cfg_r[bcnt+1]. Mask bit k applies to period k of the frame.
- thr is 9 bits and is never truncated; its range is 0..256.
- pwm_o <= (vcnt < thr), registered.
  - One-cycle latency: pwm_o in cycle t+1 reflects vcnt and thr in cycle t.
  - High count per period = min(thr, FULL). thr>=FULL gives a constant-high period.
- Frame average high cycles = 16*V + popcount(mask), with V=cfg[23:16], saturating per period as above.
- cfg_i changes mid-frame are ignored until the next frame boundary. No partial update and no glitch.
- cfg_i equal across frames: the waveform is strictly periodic with period 16*FULL.
- First frame after reset release:
  - Output is all low, since cfg_r=0.
  - The first sample occurs at cycle 16*FULL-1 after release.
  - First frame_o occurs at cycle 16*FULL after release.
- No handshake back-pressure. frame_o is informational, so software/upstream logic can align code updates.
- No combinational path from cfg_i to pwm_o.

Decomposition:
- Shared package holds:
  - PWM_CCW=24
  - PWM_FULL=255
  - PWM_BASE_MSB=23, PWM_BASE_LSB=16
  - PWM_MASK_W=16
  - a typedef for the 24-bit PWM code, reused by the slow-DAC register block
- No sub-module: counters, threshold register and comparator are a single flat module. Four instances live in the top-level.

Test Plan:
- Reset release, then cfg_i=24'h000000 for 3 frames:
  - pwm_o constantly 0.
  - frame_o pulses at cycles 4080, 8160, 12240 after release.
- cfg_i=24'h800000 from reset:
  - From the second frame, every period is 128 cycles high then 127 low.
  - 2048 high cycles per 4080-cycle frame.
- cfg_i=24'h800001:
  - Period 0 of each frame has 129 high cycles; periods 1..15 have 128.
  - Frame total 2049.
  - cfg_i=24'h80FFFF gives 129 in every period, total 2064.
- cfg_i=24'hFFFFFF (thr=256 > FULL):
  - pwm_o constantly 1 from one cycle after the first frame_o.
  - No low glitch at period wraps.
- Mid-frame update: running cfg_i=24'h400000, switch to 24'hC00000 at period 5:
  - Periods 5..15 stay 64 high.
  - The frame after the next frame_o shows 192 high per period.
- Assert rstn_i low at vcnt=50 while pwm_o=1:
  - pwm_o drops to 0 without waiting for a clock edge.
  - After release: counters restart from 0, cfg_r=0, and the first frame is all low.
